// File: rtl/wb_pkg.sv
// Shared bus widths and FSM state type for the Wishbone classic initiator.
package wb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one outstanding transfer per request, bounded
// by a saturating timeout counter that terminates the cycle with an error.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,

    // Both request and response sides use valid/ready: a transfer happens on
    // the rising edge where valid and ready are both 1; the source holds its
    // payload stable while valid is 1 and ready is 0.
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WB_AW-1:0]     req_addr,
    input  logic [WB_DW-1:0]     req_wdata,
    input  logic [WB_SELW-1:0]   req_sel,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DW-1:0]     rsp_rdata,
    output logic                 rsp_err,

    output logic [WB_AW-1:0]     wb_addr,
    output logic [WB_DW-1:0]     wb_wdata,
    output logic [WB_SELW-1:0]   wb_sel,
    output logic                 wb_we,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    input  logic [WB_DW-1:0]     wb_rdata,
    input  logic                 wb_ack,

    output logic [1:0]           dbg_state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // The cycle ending with the counter at CNT_LAST is BUS cycle number TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    wb_state_t        state;
    wb_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             ack_done;
    logic             to_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_done   = 1'b0;
        to_done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                // An ack on the final allowed cycle still completes normally.
                if (wb_ack) begin
                    ack_done   = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    to_done    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state != ST_BUS) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr   <= '0;
            wb_wdata  <= '0;
            wb_sel    <= '0;
            wb_we     <= 1'b0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wb_addr  <= req_addr;
                wb_wdata <= req_wdata;
                wb_sel   <= req_sel;
                wb_we    <= req_we;
                wb_cyc   <= 1'b1;
                wb_stb   <= 1'b1;
            end
            if (ack_done) begin
                rsp_rdata <= wb_we ? '0 : wb_rdata;
                rsp_err   <= 1'b0;
                wb_cyc    <= 1'b0;
                wb_stb    <= 1'b0;
            end else if (to_done) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
                wb_cyc    <= 1'b0;
                wb_stb    <= 1'b0;
            end
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator: a cycle-level transaction model predicts
// handshake/bus timing and a scoreboard queue predicts each response.
module tb_wb_initiator;
    import wb_pkg::*;

    localparam int TO = 8;
    localparam int RW = WB_DW + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    initial forever #5 clk = ~clk;

    logic                 req_valid, req_ready, req_we;
    logic [WB_AW-1:0]     req_addr;
    logic [WB_DW-1:0]     req_wdata;
    logic [WB_SELW-1:0]   req_sel;
    logic                 rsp_valid, rsp_ready, rsp_err;
    logic [WB_DW-1:0]     rsp_rdata;
    logic [WB_AW-1:0]     wb_addr;
    logic [WB_DW-1:0]     wb_wdata, wb_rdata;
    logic [WB_SELW-1:0]   wb_sel;
    logic                 wb_we, wb_cyc, wb_stb, wb_ack;
    logic [1:0]           dbg_state;

    wb_initiator #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_rdata(wb_rdata), .wb_ack(wb_ack),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-request stimulus extras: ack latency in BUS cycles (0 = never) and read data.
    int          req_lat;
    logic [31:0] req_rd;
    logic        bp_force = 1'b0;
    logic        stray_en = 1'b1;

    // Reference model: transfer phases and the data latched at acceptance.
    typedef enum {M_IDLE, M_BUS, M_RESP} m_phase_t;
    m_phase_t        m_phase = M_IDLE;
    int              m_left;
    int              m_lat = 0;
    logic [31:0]     m_rd, m_addr, m_wdata;
    logic [3:0]      m_sel;
    logic            m_we;
    logic [RW-1:0]   exp_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_lat   = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                M_IDLE: if (req_valid) begin
                    logic ok;
                    ok      = (req_lat >= 1) && (req_lat <= TO);
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_sel   = req_sel;
                    m_we    = req_we;
                    m_lat   = req_lat;
                    m_rd    = req_rd;
                    m_left  = ok ? req_lat : TO;
                    exp_q.push_back(ok ? {1'b0, (req_we ? 32'h0 : req_rd)} : {1'b1, 32'h0});
                    m_phase = M_BUS;
                end
                M_BUS: begin
                    m_left--;
                    if (m_left == 0) m_phase = M_RESP;
                end
                M_RESP: if (rsp_ready) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Responder: acks in BUS cycle m_lat; garbage data elsewhere, stray acks when idle.
    initial begin
        int bus_k;
        bus_k    = 0;
        wb_ack   = 1'b0;
        wb_rdata = '0;
        forever begin
            @(negedge clk);
            if (wb_cyc && wb_stb) begin
                bus_k++;
                wb_ack   = (bus_k == m_lat);
                wb_rdata = wb_ack ? m_rd : $urandom();
            end else begin
                bus_k    = 0;
                wb_ack   = stray_en && ($urandom_range(0, 3) == 0);
                wb_rdata = $urandom();
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("req_ready", req_ready, m_phase == M_IDLE);
            check("wb_cyc", wb_cyc, m_phase == M_BUS);
            check("wb_stb", wb_stb, m_phase == M_BUS);
            check("rsp_valid", rsp_valid, m_phase == M_RESP);
            if (m_phase == M_BUS)
                check("wb_fields", {wb_we, wb_sel, wb_addr, wb_wdata}, {m_we, m_sel, m_addr, m_wdata});
            if (rsp_valid && m_phase == M_RESP) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got err=%0b rdata=%0h expected no response", rsp_err, rsp_rdata);
                end else begin
                    check("rsp_data", {rsp_err, rsp_rdata}, exp_q[0]);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] sel, input int lat, input logic [31:0] rd);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        req_lat   = lat;
        req_rd    = rd;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: got req_ready=0 for %0d cycles expected 1", name, n);
        end else begin
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        req_sel   = 4'($urandom());
        req_we    = 1'($urandom());
    endtask

    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int lat, input logic [31:0] rd);
        drive_req(we, addr, wdata, sel, lat, rd);
        wait_accept(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (m_phase != M_IDLE && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (m_phase != M_IDLE) begin
            total++;
            bad++;
            $display("FAIL %s_idle: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        req_lat   = 0;
        req_rd    = '0;
        repeat (3) @(negedge clk);

        check("rst_wb_cyc", wb_cyc, 1'b0);
        check("rst_wb_stb", wb_stb, 1'b0);
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_wb_addr", wb_addr, 32'h0);
        check("rst_wb_wdata", wb_wdata, 32'h0);
        check("rst_wb_sel", wb_sel, 4'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_state", dbg_state, ST_IDLE);

        // First request is pending as reset releases: accepted on the first edge.
        drive_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 2, 32'hDEAD_BEEF);
        #1 rst_n = 1'b1;
        wait_accept("read");
        wait_idle("read");

        do_req("write", 1'b1, 32'h4, 32'h1234_5678, 4'h3, 1, 32'hA5A5_A5A5);
        do_req("timeout", 1'b0, 32'h100, 32'h0, 4'hF, 0, 32'h1111_2222);
        do_req("ack_last", 1'b0, 32'h200, 32'h0, 4'hF, TO, 32'hCAFE_F00D);
        do_req("ack_late", 1'b0, 32'h300, 32'h0, 4'h1, TO + 1, 32'h3333_4444);
        do_req("write_to", 1'b1, 32'h400, 32'h5555_6666, 4'hC, 0, 32'h7777_8888);
        wait_idle("directed");

        // Stray acks while idle must not produce anything.
        repeat (8) @(negedge clk);

        // Backpressure with a second request already pending.
        bp_force = 1'b1;
        do_req("bp_first", 1'b0, 32'h500, 32'h0, 4'hF, 3, 32'h0BAD_CAFE);
        drive_req(1'b1, 32'h504, 32'h9999_AAAA, 4'hF, 2, 32'h0);
        begin
            int n;
            n = 0;
            while (m_phase != M_RESP && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (5) @(negedge clk);
        bp_force = 1'b0;
        wait_accept("bp_second");
        wait_idle("bp");

        // Reset asserted three cycles into BUS.
        do_req("rst_mid", 1'b0, 32'h600, 32'h0, 4'hF, 0, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", wb_cyc, 1'b0);
        check("rst_mid_stb", wb_stb, 1'b0);
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        do_req("after_rst", 1'b0, 32'h700, 32'h0, 4'hF, 2, 32'h1357_9BDF);
        wait_idle("after_rst");

        // Randomized back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            int r;
            int lat;
            r = $urandom_range(0, 9);
            if (r == 0)      lat = 0;
            else if (r == 1) lat = TO + 1;
            else             lat = $urandom_range(1, TO);
            do_req("rand", 1'($urandom()), $urandom(), $urandom(), 4'($urandom()), lat, $urandom());
        end
        wait_idle("rand");
        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
